// File: rtl/taxi_eth_phy_baser_rx_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : taxi_eth_phy_baser_rx_sync_if
// Description : Signal bundle between the SERDES header path, the BASE-R
//               receive block-sync/BER monitor and the RX decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface taxi_eth_phy_baser_rx_sync_if #(
  parameter int HDR_W = 2
);
  logic [HDR_W-1:0] serdes_rx_hdr;
  logic             serdes_rx_hdr_valid;
  logic             serdes_rx_bitslip;
  logic             serdes_rx_reset_req;
  logic             rx_block_lock;
  logic             rx_high_ber;
  logic             rx_status;
  logic [6:0]       rx_error_count;
  logic             rx_bad_block;

  // Environment side: supplies headers and decoder feedback, observes status
  modport master (
    output serdes_rx_hdr,
    output serdes_rx_hdr_valid,
    output rx_bad_block,
    input  serdes_rx_bitslip,
    input  serdes_rx_reset_req,
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_status,
    input  rx_error_count
  );

  // Sync block side
  modport slave (
    input  serdes_rx_hdr,
    input  serdes_rx_hdr_valid,
    input  rx_bad_block,
    output serdes_rx_bitslip,
    output serdes_rx_reset_req,
    output rx_block_lock,
    output rx_high_ber,
    output rx_status,
    output rx_error_count
  );
endinterface
`default_nettype wire

// File: rtl/taxi_eth_phy_baser_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : taxi_eth_phy_baser_rx_sync
// Description : 64b/66b receive block lock, bitslip control, BER monitor,
//               link status, saturating error counter and SERDES reset
//               watchdog for BASE-R PHYs with 32- or 64-bit SERDES paths.
// Revision    : 1.0 - initial release
// ============================================================================
module taxi_eth_phy_baser_rx_sync #(
  parameter int HDR_W               = 2,
  parameter int LOCK_CNT            = 64,
  parameter int WIN_CNT             = 1024,
  parameter int INVLD_MAX           = 65,
  parameter int BITSLIP_HIGH_CYCLES = 0,
  parameter int BITSLIP_LOW_CYCLES  = 7,
  parameter int COUNT_125US         = 19531,
  parameter int BER_MAX             = 16,
  parameter int RESET_TIMEOUT       = 2**20
) (
  input wire clk,
  input wire rst,
  taxi_eth_phy_baser_rx_sync_if.slave rx_if
);

  localparam int LOCK_W   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = (SLIP_MAX > 0) ? $clog2(SLIP_MAX + 1) : 1;
  localparam int WIN_W    = (WIN_CNT > 1) ? $clog2(WIN_CNT) : 1;
  localparam int INV_W    = $clog2(INVLD_MAX + 1);
  localparam int TIME_W   = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam int BER_W    = $clog2(BER_MAX + 1);
  localparam int WD_W     = (RESET_TIMEOUT > 1) ? $clog2(RESET_TIMEOUT) : 1;

  // The header decode below only makes sense for a 2-bit sync header
  if (HDR_W != 2) begin : g_hdr_w_check
    $error("taxi_eth_phy_baser_rx_sync: HDR_W must be 2");
  end

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t              state_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic [SLIP_W-1:0]   slip_cnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [INV_W-1:0]    invld_cnt_q;
  logic                bitslip_q;
  logic                block_lock_q;

  logic [TIME_W-1:0]   time_cnt_q;
  logic [BER_W-1:0]    ber_cnt_q;
  logic                high_ber_q;
  logic                status_q;
  logic                clean_q;
  logic [6:0]          err_cnt_q;
  logic [6:0]          err_count_q;
  logic [WD_W-1:0]     wd_cnt_q;
  logic                reset_req_q;

  logic                hdr_ok_w;
  logic                hdr_bad_w;
  logic                win_end_w;
  logic [BER_W-1:0]    ber_inc_w;
  logic                high_ber_d;
  logic                link_ok_w;
  logic [7:0]          err_sum_w;
  logic [6:0]          err_sat_w;

  // Unqualified cycles (hdr_valid low) are neither valid nor invalid
  assign hdr_ok_w  = rx_if.serdes_rx_hdr_valid &&
                     (rx_if.serdes_rx_hdr == 2'b01 || rx_if.serdes_rx_hdr == 2'b10);
  assign hdr_bad_w = rx_if.serdes_rx_hdr_valid && !hdr_ok_w;

  // BER window closes on the last timer cycle, only while locked
  assign win_end_w = block_lock_q && (time_cnt_q == TIME_W'(COUNT_125US - 1));
  assign link_ok_w = block_lock_q && !high_ber_q;

  // Next BER count (saturating) and next high-BER flag, shared by status logic
  always_comb begin
    ber_inc_w = ber_cnt_q;
    if (hdr_bad_w && ber_cnt_q != BER_W'(BER_MAX)) begin
      ber_inc_w = ber_cnt_q + 1'b1;
    end
    high_ber_d = high_ber_q;
    if (!block_lock_q) begin
      high_ber_d = 1'b1;
    end else if (win_end_w) begin
      high_ber_d = (ber_inc_w == BER_W'(BER_MAX));
    end else if (ber_inc_w == BER_W'(BER_MAX)) begin
      high_ber_d = 1'b1;
    end
  end

  // Error increment: +1 for an invalid header, +1 for a bad block, saturate at 127
  always_comb begin
    err_sum_w = 8'(err_cnt_q) + 8'(hdr_bad_w) + 8'(rx_if.rx_bad_block);
    err_sat_w = err_sum_w[7] ? 7'd127 : err_sum_w[6:0];
  end

  // Block-lock state machine: hunt, slip pulse, hold-off, windowed lock loss
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      lock_cnt_q   <= '0;
      slip_cnt_q   <= '0;
      win_cnt_q    <= '0;
      invld_cnt_q  <= '0;
      bitslip_q    <= 1'b0;
      block_lock_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_HUNT: begin
          if (hdr_ok_w) begin
            if (lock_cnt_q == LOCK_W'(LOCK_CNT - 1)) begin
              state_q      <= ST_LOCKED;
              lock_cnt_q   <= '0;
              block_lock_q <= 1'b1;
              win_cnt_q    <= '0;
              invld_cnt_q  <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end else if (hdr_bad_w) begin
            state_q    <= ST_SLIP;
            lock_cnt_q <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b1;
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q == SLIP_W'(BITSLIP_HIGH_CYCLES)) begin
            bitslip_q  <= 1'b0;
            slip_cnt_q <= '0;
            state_q    <= (BITSLIP_LOW_CYCLES == 0) ? ST_HUNT : ST_HOLD;
          end else begin
            slip_cnt_q <= slip_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // Headers ignored here while the SERDES settles after the slip
          if (slip_cnt_q == SLIP_W'(BITSLIP_LOW_CYCLES - 1)) begin
            slip_cnt_q <= '0;
            state_q    <= ST_HUNT;
          end else begin
            slip_cnt_q <= slip_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Loss of lock wins over the window wrap on the same header
          if (hdr_bad_w && invld_cnt_q == INV_W'(INVLD_MAX - 1)) begin
            state_q      <= ST_SLIP;
            block_lock_q <= 1'b0;
            bitslip_q    <= 1'b1;
            slip_cnt_q   <= '0;
            win_cnt_q    <= '0;
            invld_cnt_q  <= '0;
          end else if (rx_if.serdes_rx_hdr_valid) begin
            if (win_cnt_q == WIN_W'(WIN_CNT - 1)) begin
              win_cnt_q   <= '0;
              invld_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              if (hdr_bad_w) begin
                invld_cnt_q <= invld_cnt_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= ST_HUNT;
        end
      endcase
    end
  end

  // BER timer and invalid-header counter, held cleared while unlocked
  always_ff @(posedge clk) begin
    if (rst) begin
      time_cnt_q <= '0;
      ber_cnt_q  <= '0;
      high_ber_q <= 1'b0;
    end else begin
      high_ber_q <= high_ber_d;
      if (!block_lock_q || win_end_w) begin
        time_cnt_q <= '0;
        ber_cnt_q  <= '0;
      end else begin
        time_cnt_q <= time_cnt_q + 1'b1;
        ber_cnt_q  <= ber_inc_w;
      end
    end
  end

  // Link status: needs one whole BER window of lock without high BER
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 1'b0;
      clean_q  <= 1'b0;
    end else begin
      if (!link_ok_w) begin
        status_q <= 1'b0;
      end else if (win_end_w) begin
        status_q <= clean_q && !high_ber_d;
      end
      if (win_end_w) begin
        clean_q <= 1'b1;
      end else if (!link_ok_w) begin
        clean_q <= 1'b0;
      end
    end
  end

  // Error counter, published once per BER window
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q   <= '0;
      err_count_q <= '0;
    end else if (!block_lock_q) begin
      err_cnt_q   <= '0;
      err_count_q <= '0;
    end else if (win_end_w) begin
      err_count_q <= err_sat_w;
      err_cnt_q   <= '0;
    end else begin
      err_cnt_q <= err_sat_w;
    end
  end

  // SERDES reset watchdog: periodic one-cycle request while unlocked
  always_ff @(posedge clk) begin
    if (rst || block_lock_q) begin
      wd_cnt_q    <= '0;
      reset_req_q <= 1'b0;
    end else if (wd_cnt_q == WD_W'(RESET_TIMEOUT - 1)) begin
      wd_cnt_q    <= '0;
      reset_req_q <= 1'b1;
    end else begin
      wd_cnt_q    <= wd_cnt_q + 1'b1;
      reset_req_q <= 1'b0;
    end
  end

  assign rx_if.serdes_rx_bitslip   = bitslip_q;
  assign rx_if.serdes_rx_reset_req = reset_req_q;
  assign rx_if.rx_block_lock       = block_lock_q;
  assign rx_if.rx_high_ber         = high_ber_q;
  assign rx_if.rx_status           = status_q;
  assign rx_if.rx_error_count      = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_eth_phy_baser_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_taxi_eth_phy_baser_rx_sync
// Description : Directed self-checking bench for the BASE-R RX block sync:
//               reset, watchdog, slip timing, qualified lock, BER/status,
//               error count, windowed lock loss and reset during slip.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taxi_eth_phy_baser_rx_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  taxi_eth_phy_baser_rx_sync_if #(.HDR_W(2)) rx_if ();

  taxi_eth_phy_baser_rx_sync #(
    .HDR_W               (2),
    .LOCK_CNT            (64),
    .WIN_CNT             (1024),
    .INVLD_MAX           (65),
    .BITSLIP_HIGH_CYCLES (1),
    .BITSLIP_LOW_CYCLES  (3),
    .COUNT_125US         (256),
    .BER_MAX             (16),
    .RESET_TIMEOUT       (100)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h, input logic v, input logic bb);
    rx_if.serdes_rx_hdr       = h;
    rx_if.serdes_rx_hdr_valid = v;
    rx_if.rx_bad_block        = bb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b01, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_bitslip"}, 32'(rx_if.serdes_rx_bitslip), 0);
    check_eq({tag, "_rreq"},    32'(rx_if.serdes_rx_reset_req), 0);
    check_eq({tag, "_lock"},    32'(rx_if.rx_block_lock), 0);
    check_eq({tag, "_hiber"},   32'(rx_if.rx_high_ber), 0);
    check_eq({tag, "_status"},  32'(rx_if.rx_status), 0);
    check_eq({tag, "_errcnt"},  32'(rx_if.rx_error_count), 0);
  endtask

  function automatic logic is_bad(input int s);
    return (s >= 513 && s <= 528) || s == 773 ||
           (s >= 1985 && s <= 2112) ||
           (s >= 3073 && s <= 4096 && ((s - 3073) % 16) == 0) ||
           (s >= 4097 && s <= 4160) || s == 5120;
  endfunction

  initial begin
    #10ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int extra;
    logic b;

    // Reset values
    do_reset();
    rst = 1'b1;
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Watchdog: constant invalid headers, request every 100 cycles
    pulses = 0;
    drive(2'b11, 1'b1, 1'b0);
    for (int s = 1; s <= 300; s++) begin
      tick();
      if (rx_if.serdes_rx_reset_req) pulses++;
      if (s == 99)  check_eq("wd_c99",  32'(rx_if.serdes_rx_reset_req), 0);
      if (s == 100) check_eq("wd_c100", 32'(rx_if.serdes_rx_reset_req), 1);
      if (s == 101) check_eq("wd_c101", 32'(rx_if.serdes_rx_reset_req), 0);
      if (s == 200) check_eq("wd_c200", 32'(rx_if.serdes_rx_reset_req), 1);
      if (s == 300) check_eq("wd_c300", 32'(rx_if.serdes_rx_reset_req), 1);
    end
    check_eq("wd_pulses", pulses, 3);

    // Slip timing: one bad header, 2-cycle pulse, 3 ignored headers
    do_reset();
    extra = 0;
    for (int s = 1; s <= 70; s++) begin
      drive((s <= 6) ? 2'b11 : 2'b01, 1'b1, 1'b0);
      tick();
      if (s == 1) check_eq("slip_hi1", 32'(rx_if.serdes_rx_bitslip), 1);
      if (s == 2) check_eq("slip_hi2", 32'(rx_if.serdes_rx_bitslip), 1);
      if (s == 3) check_eq("slip_lo3", 32'(rx_if.serdes_rx_bitslip), 0);
      if (s >= 3 && rx_if.serdes_rx_bitslip) extra++;
      if (s == 69) check_eq("slip_lock69", 32'(rx_if.rx_block_lock), 0);
      if (s == 70) check_eq("slip_lock70", 32'(rx_if.rx_block_lock), 1);
    end
    check_eq("slip_extra", extra, 0);

    // Qualifier: 32-bit path, header valid every other cycle
    do_reset();
    extra = 0;
    for (int s = 1; s <= 128; s++) begin
      if (s % 2 == 0) drive(2'b01, 1'b1, 1'b0);
      else            drive(2'b00, 1'b0, 1'b0);
      tick();
      if (rx_if.serdes_rx_bitslip) extra++;
      if (s == 127) check_eq("qual_lock127", 32'(rx_if.rx_block_lock), 0);
      if (s == 128) check_eq("qual_lock128", 32'(rx_if.rx_block_lock), 1);
    end
    check_eq("qual_slips", extra, 0);

    // Lock acquisition on a 64-bit path
    do_reset();
    extra = 0;
    for (int s = 1; s <= 64; s++) begin
      drive(2'b10, 1'b1, 1'b0);
      tick();
      if (rx_if.serdes_rx_bitslip) extra++;
      if (s == 1)  check_eq("acq_hiber_unlocked", 32'(rx_if.rx_high_ber), 1);
      if (s == 63) check_eq("acq_lock63", 32'(rx_if.rx_block_lock), 0);
      if (s == 64) check_eq("acq_lock64", 32'(rx_if.rx_block_lock), 1);
    end
    check_eq("acq_slips", extra, 0);

    // BER windows, status, error count, then windowed lock loss
    extra = 0;
    for (int s = 1; s <= 5120; s++) begin
      b = is_bad(s);
      drive(b ? 2'b11 : 2'b01, 1'b1, (s >= 770 && s <= 773));
      tick();
      if (s < 5120 && rx_if.serdes_rx_bitslip) extra++;
      case (s)
        255:  check_eq("ber_w1_hiber",  32'(rx_if.rx_high_ber), 1);
        256: begin
          check_eq("ber_w1end_hiber",  32'(rx_if.rx_high_ber), 0);
          check_eq("ber_w1end_status", 32'(rx_if.rx_status), 0);
          check_eq("ber_w1end_err",    32'(rx_if.rx_error_count), 0);
        end
        511:  check_eq("ber_w2_status", 32'(rx_if.rx_status), 0);
        512: begin
          check_eq("ber_w2end_status", 32'(rx_if.rx_status), 1);
          check_eq("ber_w2end_err",    32'(rx_if.rx_error_count), 0);
        end
        527:  check_eq("ber_15bad_hiber", 32'(rx_if.rx_high_ber), 0);
        528: begin
          check_eq("ber_16bad_hiber",  32'(rx_if.rx_high_ber), 1);
          check_eq("ber_16bad_status", 32'(rx_if.rx_status), 1);
        end
        529:  check_eq("ber_status_drop", 32'(rx_if.rx_status), 0);
        768: begin
          check_eq("ber_w3end_hiber", 32'(rx_if.rx_high_ber), 1);
          check_eq("ber_w3end_err",   32'(rx_if.rx_error_count), 16);
        end
        1024: begin
          check_eq("ber_w4end_hiber",  32'(rx_if.rx_high_ber), 0);
          check_eq("ber_w4end_status", 32'(rx_if.rx_status), 0);
          check_eq("ber_w4end_err",    32'(rx_if.rx_error_count), 5);
        end
        1280: begin
          check_eq("ber_w5end_hiber",  32'(rx_if.rx_high_ber), 0);
          check_eq("ber_w5end_status", 32'(rx_if.rx_status), 1);
          check_eq("ber_w5end_err",    32'(rx_if.rx_error_count), 0);
        end
        2048: check_eq("loss_win2_lock", 32'(rx_if.rx_block_lock), 1);
        3072: check_eq("loss_win3_lock", 32'(rx_if.rx_block_lock), 1);
        4096: check_eq("loss_win4_lock", 32'(rx_if.rx_block_lock), 1);
        5119: check_eq("loss_64th_lock", 32'(rx_if.rx_block_lock), 1);
        5120: begin
          check_eq("loss_65th_lock",    32'(rx_if.rx_block_lock), 0);
          check_eq("loss_65th_bitslip", 32'(rx_if.serdes_rx_bitslip), 1);
        end
        default: ;
      endcase
    end
    check_eq("locked_slips", extra, 0);

    // Reset asserted while in SLIP
    rst = 1'b1;
    tick();
    check_all_zero("rst_slip");
    rst = 1'b0;
    drive(2'b01, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/taxi_eth_phy_baser_rx_sync.md
Name: taxi_eth_phy_baser_rx_sync

Overview:
- Parametrised 64b/66b receive block-lock, bitslip and BER monitor for BASE-R PHYs at 10G/25G with 32- or 64-bit SERDES paths.
- Sits between the SERDES header output and the RX decoder.
- Compared with the current fixed 10G frame sync, it adds:
  - a header-valid qualifier, so gearbox-fed 32-bit paths work;
  - a windowed loss-of-lock criterion;
  - a configurable bitslip pulse and hold-off;
  - a SERDES reset watchdog;
  - saturating error counting.

Parameters:
- HDR_W, 2, sync header width (fixed at 2, checked at elaboration).
- LOCK_CNT, 64, consecutive valid headers required to declare lock.
- WIN_CNT, 1024, header window size while locked.
- INVLD_MAX, 65, invalid headers within one window that cause loss of lock.
- BITSLIP_HIGH_CYCLES, 0, extra cycles bitslip stays high (pulse length = value+1).
- BITSLIP_LOW_CYCLES, 7, hold-off cycles after the bitslip pulse, during which headers are ignored.
- COUNT_125US, 19531, clock cycles per 125 us BER window.
- BER_MAX, 16, invalid headers within one BER window that set high_ber.
- RESET_TIMEOUT, 2**20, cycles without lock before a SERDES reset request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- serdes_rx_hdr  in  HDR_W  received sync header
- serdes_rx_hdr_valid  in  1  header qualifier (tied high on 64-bit paths)
- serdes_rx_bitslip  out  1  slip request to SERDES
- serdes_rx_reset_req  out  1  one-cycle SERDES reset request
- rx_block_lock  out  1  block lock achieved
- rx_high_ber  out  1  high bit error ratio detected
- rx_status  out  1  link status
- rx_error_count  out  7  invalid headers in the last completed BER window, saturating at 127
- rx_bad_block  in  1  decoder bad-block flag, counted into the error count

Behaviour:
- All logic is in clk; reset is synchronous and active-high.
- Reset values of all outputs and counters are 0; the FSM resets to HUNT.
- Header test: valid = hdr_valid && (hdr==2'b01 || hdr==2'b10); invalid = hdr_valid && !valid. Cycles with hdr_valid low change no header counters.
- FSM state HUNT:
  - valid header: lock_cnt++; when lock_cnt reaches LOCK_CNT-1 on a valid header, go to LOCKED next cycle with lock_cnt cleared.
  - invalid header: go to SLIP and clear lock_cnt.
- FSM state SLIP:
  - serdes_rx_bitslip is high for BITSLIP_HIGH_CYCLES+1 cycles, then go to HOLD.
- FSM state HOLD:
  - bitslip is low; headers are ignored for BITSLIP_LOW_CYCLES cycles, then go to HUNT.
  - With BITSLIP_LOW_CYCLES=0, go straight to HUNT.
- FSM state LOCKED:
  - rx_block_lock=1 and is registered, asserting the cycle after entry.
  - win_cnt counts qualified headers; invld_cnt counts invalid ones.
  - When invld_cnt reaches INVLD_MAX, go to SLIP, drop lock, and clear both counters.
  - When win_cnt wraps at WIN_CNT with invld_cnt < INVLD_MAX, clear both counters and stay LOCKED.
  - If the final header of a window is the INVLD_MAX-th invalid one, loss of lock takes precedence over the wrap.
- BER monitor:
  - Runs only while rx_block_lock is high; otherwise the timer and counter are held cleared and rx_high_ber=1.
  - ber_cnt counts invalid headers; time_cnt runs 0..COUNT_125US-1.
  - When ber_cnt reaches BER_MAX, rx_high_ber=1 immediately (next cycle).
  - At the window end, rx_high_ber is re-evaluated as ber_cnt>=BER_MAX and ber_cnt is cleared. An invalid header in the terminal cycle counts toward the closing window.
- rx_status:
  - Set after rx_block_lock && !rx_high_ber holds for one full BER window.
  - Cleared on the cycle after either condition fails.
- Error counter:
  - An internal counter increments on invalid header OR rx_bad_block (+1 if either, +2 if both), saturating at 127.
  - rx_error_count latches the counter at each BER window end, then the counter clears.
  - rx_error_count holds 0 while unlocked.
- Reset watchdog:
  - Counts cycles with rx_block_lock low.
  - At RESET_TIMEOUT-1, pulse serdes_rx_reset_req for one cycle and restart the count.
  - Cleared whenever rx_block_lock is high.
- Reset mid-operation: any state returns to HUNT with bitslip deasserted the same edge.

Test Plan:
- Small-parameter benches use LOCK_CNT=64, WIN_CNT=1024, INVLD_MAX=65, COUNT_125US=256, BER_MAX=16 unless a scenario states otherwise.
- Lock acquisition: 64 consecutive valid headers (hdr_valid=1) -> rx_block_lock rises the cycle after the 64th; no bitslip pulses.
- Slip timing: with BITSLIP_HIGH_CYCLES=1 and BITSLIP_LOW_CYCLES=3, one 2'b11 header in HUNT -> bitslip high exactly 2 cycles, then 3 ignored headers, then counting resumes.
- Lock loss: in LOCKED, 65 invalid headers inside a 1024-header window -> lock drops after the 65th. With 64 invalid per window for 3 windows -> lock held.
- Qualifier: 32-bit mode with hdr_valid toggling and 2'b00 on invalid cycles -> lock after 64 qualified headers (128 cycles); the 2'b00 cycles are ignored.
- BER: with COUNT_125US=256, 16 invalid headers in one window -> rx_high_ber=1 and rx_status=0. A following clean window -> rx_high_ber=0, rx_status=1 one window later, rx_error_count=0.
- Watchdog and reset: with RESET_TIMEOUT=100 and constant 2'b11 input -> reset_req pulses at cycles 100, 200, 300. Asserting rst mid-SLIP -> bitslip=0 the next cycle and all outputs read 0.
